// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package pkg_fetch;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_READ,
    FETCH_LAST,
    FETCH_DONE
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int JMP_SHIFT   = 2;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads four big-endian bytes per instruction
// from a byte-wide RAM with one-cycle read latency, and strobes ir_valid.
module instr_fetch
  import pkg_fetch::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              advance,
  input  logic              jmp_valid,
  input  logic [23:0]       jmp_offset,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  localparam logic [1:0] LAST_CNT = 2'(INSTR_BYTES - 1);

  fetch_state_t      state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] jmp_delta;

  // Offset counts instructions; truncating before the shift is harmless modulo 2^ADDR_W.
  assign jmp_delta = ADDR_W'($signed(jmp_offset)) << JMP_SHIFT;

  always_comb begin
    pc_n = pc_q;
    if (jmp_valid) begin
      pc_n = pc_q + jmp_delta;
    end else if (advance) begin
      pc_n = pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ram_addr_d = ram_addr_q;
    case (state_q)
      FETCH_IDLE: begin
        pc_d = pc_n;
        if (start) begin
          state_d    = FETCH_READ;
          cnt_d      = 2'd0;
          ram_addr_d = pc_n;
        end
      end
      FETCH_READ: begin
        cnt_d = cnt_q + 2'd1;
        // Data for the read issued last cycle arrives now.
        if (cnt_q != 2'd0) begin
          ir_d = {ir_q[23:0], ram_rdata};
        end
        if (cnt_q == LAST_CNT) begin
          state_d = FETCH_LAST;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      FETCH_LAST: begin
        ir_d    = {ir_q[23:0], ram_rdata};
        state_d = FETCH_DONE;
      end
      FETCH_DONE: begin
        state_d = FETCH_IDLE;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      cnt_q      <= 2'd0;
      pc_q       <= ADDR_W'(RESET_PC);
      ram_addr_q <= '0;
      ir_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      ram_addr_q <= ram_addr_d;
      ir_q       <= ir_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_re   = (state_q == FETCH_READ);
  assign ir       = ir_q;
  assign ir_valid = (state_q == FETCH_DONE);
  assign pc       = pc_q;
  assign busy     = (state_q != FETCH_IDLE);

endmodule
